// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline register with 2-entry skid buffer and flush
// Optional stall/bubble counters are built only when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_reg #(
    parameter int PAYLOAD_W = 160,
    parameter int CNT_W     = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    logic                 r_m_valid;
    logic [PAYLOAD_W-1:0] r_m_data;
    logic                 r_s_valid;
    logic [PAYLOAD_W-1:0] r_s_data;

    logic w_accept;
    logic w_main_free;

    // in_ready comes straight from the skid flop, so out_ready never reaches it combinationally.
    assign in_ready    = !r_s_valid;
    assign out_valid   = r_m_valid;
    assign out_data    = r_m_data;
    assign w_accept    = in_valid && !r_s_valid;
    assign w_main_free = !r_m_valid || out_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
            r_m_data  <= '0;
            r_s_data  <= '0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (w_main_free) begin
            if (r_s_valid) begin
                r_m_valid <= 1'b1;
                r_m_data  <= r_s_data;
                r_s_valid <= 1'b0;
            end else if (w_accept) begin
                r_m_valid <= 1'b1;
                r_m_data  <= in_data;
            end else begin
                r_m_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_s_valid <= 1'b1;
            r_s_data  <= in_data;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    // Saturating counters; flush deliberately leaves them alone.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (r_m_valid && !out_ready && (r_stall_cnt != CNT_MAX))
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (!r_m_valid && (r_bubble_cnt != CNT_MAX))
                r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed and random scoreboard bench for pipe_stage_reg
// Counter expectations follow PIPE_STAGE_STATS_EN.
module tb_pipe_stage_reg;

    localparam int PW = 16;
    localparam int CW = 2;

    logic          CLK = 1'b0;
    logic          RST;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_data;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] bubble_cnt;

    int tests = 0;
    int fails = 0;
    int n_acc = 0;
    int n_sent = 0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] exp_v;

    pipe_stage_reg #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 CLK = ~CLK;

`ifdef PIPE_STAGE_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard: push on accept, pop on send; the DUT state seen at negedge is what the next edge samples.
    always @(negedge CLK) begin
        if (RST) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_sent++;
                tests++;
                assert (exp_q.size() > 0) else begin
                    fails++;
                    $error("FAIL sb_unexpected_send: observed 0x%0h expected none", out_data);
                end
                if (exp_q.size() > 0) begin
                    exp_v = exp_q.pop_front();
                    check("sb_order", 32'(out_data), 32'(exp_v));
                end
            end
            if (flush)
                exp_q.delete();
            else if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                n_acc++;
            end
        end
    end

    initial begin
        RST = 1'b1; in_valid = 1'b1; in_data = 16'h00AA; flush = 1'b0; out_ready = 1'b0;
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        check("rst_bubble", 32'(bubble_cnt), 32'd0);
        RST = 1'b0; in_valid = 1'b0;
        step();

        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_data = PW'(i);
            step();
            check("pt_out_data", 32'(out_data), 32'(i));
            check("pt_in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("pt_drained", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h0010;
        step();
        check("skid_first", 32'(out_data), 32'h10);
        in_data = 16'h0011;
        step();
        check("skid_full_ready", 32'(in_ready), 32'd0);
        check("skid_hold", 32'(out_data), 32'h10);
        in_valid = 1'b0;
        step();
        check("skid_hold2", 32'(out_data), 32'h10);
        out_ready = 1'b1;
        step();
        check("skid_second", 32'(out_data), 32'h11);
        check("skid_ready_back", 32'(in_ready), 32'd1);
        step();
        check("skid_empty", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h0020;
        step();
        in_data = 16'h0021;
        step();
        check("fl_full", 32'(in_ready), 32'd0);
        in_data = 16'h0022; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = 16'h0023; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_accept_dropped", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        step();
        step();
        check("fl_never_out", 32'(out_valid), 32'd0);

        RST = 1'b1;
        step();
        RST = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("st_bubble_sat", 32'(bubble_cnt), (STATS != 0) ? 32'd3 : 32'd0);
        check("st_stall_idle", 32'(stall_cnt), 32'd0);
        in_valid = 1'b1; in_data = 16'h0030;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("st_stall_mid", 32'(stall_cnt), (STATS != 0) ? 32'd2 : 32'd0);
        step();
        step();
        check("st_stall_sat", 32'(stall_cnt), (STATS != 0) ? 32'd3 : 32'd0);
        check("st_bubble_hold", 32'(bubble_cnt), (STATS != 0) ? 32'd3 : 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("st_flush_keeps", 32'(stall_cnt), (STATS != 0) ? 32'd3 : 32'd0);

        n_acc = 0; n_sent = 0;
        for (int i = 0; i < 1000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = PW'(16'h1000 + i);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
        check("rnd_count", 32'(n_sent), 32'(n_acc));
        check("rnd_drained", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
